// File: rtl/lc3_br_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lc3_br_sequencer
// Brief    : Reduced LC-3 microsequencer for fetch, decode, BR, ADD, AND, NOT.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_br_sequencer #(
    parameter int STATE_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [15:0]        ir,
    input  logic               ben,
    input  logic               mem_ready,
    output logic               ld_mar,
    output logic               ld_mdr,
    output logic               ld_ir,
    output logic               ld_ben,
    output logic               ld_reg,
    output logic               ld_cc,
    output logic               ld_pc,
    output logic               gate_pc,
    output logic               gate_mdr,
    output logic               gate_alu,
    output logic [1:0]         pcmux,
    output logic [1:0]         aluk,
    output logic               mem_en,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count
);

    // State numbers match the LC-3 microarchitecture state chart.
    typedef enum logic [STATE_W-1:0] {
        c_st_br       = STATE_W'(0),
        c_st_add      = STATE_W'(1),
        c_st_and      = STATE_W'(5),
        c_st_not      = STATE_W'(9),
        c_st_illegal  = STATE_W'(13),
        c_st_fetch    = STATE_W'(18),
        c_st_br_taken = STATE_W'(22),
        c_st_decode   = STATE_W'(32),
        c_st_read     = STATE_W'(33),
        c_st_load_ir  = STATE_W'(35)
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_instr_count;
    logic               w_unused_ir;

    assign w_unused_ir = ^ir[11:0];

    always_comb begin
        w_next = c_st_fetch;
        case (r_state)
            c_st_fetch:    w_next = run ? c_st_read : c_st_fetch;
            c_st_read:     w_next = mem_ready ? c_st_load_ir : c_st_read;
            c_st_load_ir:  w_next = c_st_decode;
            c_st_decode: begin
                case (ir[15:12])
                    4'b0000: w_next = c_st_br;
                    4'b0001: w_next = c_st_add;
                    4'b0101: w_next = c_st_and;
                    4'b1001: w_next = c_st_not;
                    default: w_next = c_st_illegal;
                endcase
            end
            c_st_br:       w_next = ben ? c_st_br_taken : c_st_fetch;
            default:       w_next = c_st_fetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_st_fetch;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_st_load_ir)
                r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Strobes are held low for as long as reset is asserted, even though the
    // state register already reads the fetch state.
    always_comb begin
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        ld_ir      = 1'b0;
        ld_ben     = 1'b0;
        ld_reg     = 1'b0;
        ld_cc      = 1'b0;
        ld_pc      = 1'b0;
        gate_pc    = 1'b0;
        gate_mdr   = 1'b0;
        gate_alu   = 1'b0;
        pcmux      = 2'b00;
        aluk       = 2'b00;
        mem_en     = 1'b0;
        illegal_op = 1'b0;
        if (rst) begin
            case (r_state)
                c_st_fetch: begin
                    if (run) begin
                        ld_mar  = 1'b1;
                        gate_pc = 1'b1;
                        ld_pc   = 1'b1;
                    end
                end
                c_st_read: begin
                    mem_en = 1'b1;
                    ld_mdr = mem_ready;
                end
                c_st_load_ir: begin
                    gate_mdr = 1'b1;
                    ld_ir    = 1'b1;
                end
                c_st_decode:   ld_ben = 1'b1;
                c_st_br_taken: begin
                    ld_pc = 1'b1;
                    pcmux = 2'b01;
                end
                c_st_add, c_st_and, c_st_not: begin
                    gate_alu = 1'b1;
                    ld_reg   = 1'b1;
                    ld_cc    = 1'b1;
                    aluk     = (r_state == c_st_and) ? 2'b01 :
                               (r_state == c_st_not) ? 2'b10 : 2'b00;
                end
                c_st_illegal:  illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_lc3_br_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_br_sequencer
// Brief    : Scoreboard bench: per-cycle expected state/strobes/count queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_br_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [15:0] ir = 16'h0000;
    logic        ben = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
    logic        gate_pc, gate_mdr, gate_alu, mem_en, illegal_op;
    logic [1:0]  pcmux, aluk;
    logic [5:0]  state;
    logic [15:0] instr_count;

    lc3_br_sequencer #(.STATE_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .ir(ir), .ben(ben), .mem_ready(mem_ready),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_ben(ld_ben),
        .ld_reg(ld_reg), .ld_cc(ld_cc), .ld_pc(ld_pc), .gate_pc(gate_pc),
        .gate_mdr(gate_mdr), .gate_alu(gate_alu), .pcmux(pcmux), .aluk(aluk),
        .mem_en(mem_en), .illegal_op(illegal_op), .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Output bundle: {ld_mar,ld_mdr,ld_ir,ld_ben,ld_reg,ld_cc,ld_pc,gate_pc,
    //                 gate_mdr,gate_alu,mem_en,illegal_op,pcmux,aluk}
    localparam logic [15:0] c_mar  = 16'h8000;
    localparam logic [15:0] c_mdr  = 16'h4000;
    localparam logic [15:0] c_ir   = 16'h2000;
    localparam logic [15:0] c_ben  = 16'h1000;
    localparam logic [15:0] c_reg  = 16'h0800;
    localparam logic [15:0] c_cc   = 16'h0400;
    localparam logic [15:0] c_pc   = 16'h0200;
    localparam logic [15:0] c_gpc  = 16'h0100;
    localparam logic [15:0] c_gmdr = 16'h0080;
    localparam logic [15:0] c_galu = 16'h0040;
    localparam logic [15:0] c_mem  = 16'h0020;
    localparam logic [15:0] c_ill  = 16'h0010;
    localparam logic [15:0] c_pcmux_off = 16'h0004;

    logic [15:0] w_outs;
    assign w_outs = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc, gate_pc,
                     gate_mdr, gate_alu, mem_en, illegal_op, pcmux, aluk};

    typedef struct packed {
        logic [5:0]  st;
        logic [15:0] outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_count = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int st, input logic [15:0] o);
        exp_t e;
        e.st   = 6'(st);
        e.outs = o;
        e.cnt  = exp_count;
        q.push_back(e);
    endtask

    // Expected cycle-by-cycle trace of one instruction with 'waits' memory stalls.
    task automatic queue_instr(input logic [15:0] ir_v, input logic ben_v, input int waits);
        logic [3:0] op;
        op = ir_v[15:12];
        push(18, c_mar | c_gpc | c_pc);
        repeat (waits) push(33, c_mem);
        push(33, c_mem | c_mdr);
        push(35, c_gmdr | c_ir);
        exp_count = exp_count + 16'h0001;
        push(32, c_ben);
        case (op)
            4'b0000: begin
                push(0, 16'h0000);
                if (ben_v) push(22, c_pc | c_pcmux_off);
            end
            4'b0001: push(1, c_galu | c_reg | c_cc);
            4'b0101: push(5, c_galu | c_reg | c_cc | 16'h0001);
            4'b1001: push(9, c_galu | c_reg | c_cc | 16'h0002);
            default: push(13, c_ill);
        endcase
    endtask

    // run is raised only for fetch cycles; mid-instruction it is held low.
    task automatic drain(input logic [15:0] ir_v, input logic ben_v);
        exp_t e;
        while (q.size() > 0) begin
            @(negedge clk);
            e         = q[0];
            ir        = ir_v;
            ben       = ben_v;
            run       = (e.st == 6'd18) && (e.outs != 16'h0000);
            mem_ready = (e.outs & c_mdr) != 16'h0000;
            #1;
            e = q.pop_front();
            check("state", {26'd0, state}, {26'd0, e.st});
            check("strobes", {16'd0, w_outs}, {16'd0, e.outs});
            check("instr_count", {16'd0, instr_count}, {16'd0, e.cnt});
        end
    endtask

    task automatic run_instr(input logic [15:0] ir_v, input logic ben_v, input int waits);
        queue_instr(ir_v, ben_v, waits);
        drain(ir_v, ben_v);
    endtask

    initial begin
        // Reset held with run and mem_ready high: nothing may strobe.
        run = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("reset_state", {26'd0, state}, 32'd18);
        check("reset_strobes", {16'd0, w_outs}, 32'd0);
        check("reset_count", {16'd0, instr_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;

        push(18, 16'h0000);
        push(18, 16'h0000);
        drain(16'h0000, 1'b0);

        run_instr(16'h1042, 1'b0, 0);   // ADD
        run_instr(16'h0E05, 1'b1, 0);   // BR taken
        run_instr(16'h0E05, 1'b0, 0);   // BR not taken
        run_instr(16'h5123, 1'b0, 4);   // AND with 4 memory stalls
        run_instr(16'hF025, 1'b0, 0);   // TRAP -> illegal
        run_instr(16'h9FFF, 1'b0, 1);   // NOT
        push(18, 16'h0000);
        drain(16'h0000, 1'b0);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.r_instr_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_instr_count;
        exp_count = 16'hFFFF;
        run_instr(16'h1042, 1'b0, 0);
        check("wrap_count", {16'd0, instr_count}, 32'd0);

        // Reset while stalled in the memory read state.
        push(18, c_mar | c_gpc | c_pc);
        push(33, c_mem);
        push(33, c_mem);
        drain(16'h1042, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_s33_state", {26'd0, state}, 32'd18);
        check("rst_s33_strobes", {16'd0, w_outs}, 32'd0);
        check("rst_s33_count", {16'd0, instr_count}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_hold_state", {26'd0, state}, 32'd18);
        rst = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        exp_count = 16'h0000;
        run_instr(16'h5FFF, 1'b0, 2);
        push(18, 16'h0000);
        drain(16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
